// File: rtl/v_piso_tx_if.sv
// Load handshake and serial strobe bundle for v_piso_tx.
// master = upstream/downstream environment, slave = the transmitter.
interface v_piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             ce;
  logic             ld;
  logic [WIDTH-1:0] d;
  logic             rdy;
  logic             so;
  logic             sv;
  logic             fs;
  logic             ls;
  logic             done;

  modport master (
    output ce, ld, d,
    input  rdy, so, sv, fs, ls, done
  );

  modport slave (
    input  ce, ld, d,
    output rdy, so, sv, fs, ls, done
  );
endinterface

// File: rtl/v_piso_tx.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word on a CE-qualified
// handshake and shifts it out one bit per enabled clock with framing strobes.
module v_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LVL  = 1'b1
) (
  input  logic        c,
  input  logic        clr_n,
  v_piso_tx_if.slave  bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  logic [0:0]       state_r, state_s;
  logic [WIDTH-1:0] sr_r, sr_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             so_r, so_s;
  logic             sv_r, sv_s;
  logic             fs_r, fs_s;
  logic             ls_r, ls_s;
  logic             done_r, done_s;
  logic             rdy_s;
  logic             accept_s;

  // The bit presented first; after a shift the next bit sits in the same place.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b1} : {1'b1, w[WIDTH-1:1]};
  endfunction

  // RDY also opens on the last bit so a new word can follow with no gap.
  assign rdy_s    = (state_r == ST_IDLE) | ls_r;
  assign accept_s = bus.ce & bus.ld & rdy_s;

  // Next-state and next-output selection.
  always_comb begin
    state_s = state_r;
    sr_s    = sr_r;
    cnt_s   = cnt_r;
    so_s    = so_r;
    sv_s    = sv_r;
    fs_s    = fs_r;
    ls_s    = ls_r;
    done_s  = 1'b0;
    if (bus.ce == 1'b0) begin
      done_s = 1'b0;
    end else if (accept_s) begin
      state_s = ST_SHIFT;
      sr_s    = bus.d;
      cnt_s   = {CW{1'b0}};
      so_s    = head_bit(bus.d);
      sv_s    = 1'b1;
      fs_s    = 1'b1;
      ls_s    = 1'b0;
      done_s  = ls_r;
    end else begin
      case (state_r)
        ST_SHIFT: begin
          if (cnt_r != CNT_LAST) begin
            sr_s  = shift_word(sr_r);
            so_s  = head_bit(shift_word(sr_r));
            cnt_s = cnt_r + CW'(1);
            fs_s  = 1'b0;
            ls_s  = (cnt_r == CNT_PRE);
          end else begin
            state_s = ST_IDLE;
            so_s    = IDLE_LVL;
            sv_s    = 1'b0;
            fs_s    = 1'b0;
            ls_s    = 1'b0;
            done_s  = 1'b1;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
          sr_s    = {WIDTH{1'b1}};
          cnt_s   = {CW{1'b0}};
          so_s    = IDLE_LVL;
          sv_s    = 1'b0;
          fs_s    = 1'b0;
          ls_s    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset drops any word in flight immediately.
  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      state_r <= ST_IDLE;
      sr_r    <= {WIDTH{1'b1}};
      cnt_r   <= {CW{1'b0}};
      so_r    <= IDLE_LVL;
      sv_r    <= 1'b0;
      fs_r    <= 1'b0;
      ls_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      cnt_r   <= cnt_s;
      so_r    <= so_s;
      sv_r    <= sv_s;
      fs_r    <= fs_s;
      ls_r    <= ls_s;
      done_r  <= done_s;
    end
  end

  assign bus.rdy  = rdy_s;
  assign bus.so   = so_r;
  assign bus.sv   = sv_r;
  assign bus.fs   = fs_r;
  assign bus.ls   = ls_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_v_piso_tx.sv
// Scoreboard bench for v_piso_tx: a word-level model queues the expected outputs
// per clock; independent monitors pop and compare after each rising edge.
module tb_v_piso_tx;

  localparam logic IDLE_LVL = 1'b1;

  logic c = 1'b0;
  logic clr_n = 1'b1;

  v_piso_tx_if #(.WIDTH(4)) m_if ();
  v_piso_tx_if #(.WIDTH(4)) l4_if ();
  v_piso_tx_if #(.WIDTH(8)) l8_if ();

  v_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_msb4 (.c(c), .clr_n(clr_n), .bus(m_if));
  v_piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_lsb4 (.c(c), .clr_n(clr_n), .bus(l4_if));
  v_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_lsb8 (.c(c), .clr_n(clr_n), .bus(l8_if));

  typedef struct packed {
    logic so;
    logic sv;
    logic fs;
    logic ls;
    logic done;
  } exp_t;

  typedef struct packed {
    logic so;
    logic ls;
  } lbit_t;

  exp_t  sb[$];
  exp_t  cur_exp;
  logic  word_bits[$];
  int    rem;
  bit    mon_en;
  lbit_t q4[$];
  lbit_t q8[$];
  int    n_chk;
  int    n_pass;

  initial begin
    forever #5 c = ~c;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock of stimulus for the MSB-first DUT; the model predicts the edge's outcome.
  task automatic step(input logic ce_i, input logic ld_i, input logic [3:0] d_i);
    exp_t e;
    @(negedge c);
    check("rdy", 32'(m_if.rdy), 32'(rem <= 1));
    m_if.ce = ce_i;
    m_if.ld = ld_i;
    m_if.d  = d_i;
    if (!ce_i) begin
      e = cur_exp;
      e.done = 1'b0;
    end else if (ld_i && rem <= 1) begin
      word_bits.delete();
      for (int i = 3; i >= 0; i--) word_bits.push_back(d_i[i]);
      e.so   = word_bits.pop_front();
      e.sv   = 1'b1;
      e.fs   = 1'b1;
      e.ls   = 1'b0;
      e.done = (rem == 1);
      rem = 4;
    end else if (rem > 1) begin
      e.so   = word_bits.pop_front();
      e.sv   = 1'b1;
      e.fs   = 1'b0;
      e.ls   = (rem == 2);
      e.done = 1'b0;
      rem--;
    end else if (rem == 1) begin
      e = '{IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b1};
      rem = 0;
    end else begin
      e = '{IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b0};
    end
    cur_exp = e;
    sb.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_outs"}, 32'({m_if.so, m_if.sv, m_if.fs, m_if.ls, m_if.done}),
          32'({IDLE_LVL, 4'b0000}));
    check({name, "_rdy"}, 32'(m_if.rdy), 32'(1'b1));
  endtask

  // Pull reset between edges and confirm the outputs react before any clock.
  task automatic mid_reset();
    @(negedge c);
    m_if.ce = 1'b0;
    m_if.ld = 1'b0;
    #2;
    clr_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge c);
    #2;
    clr_n = 1'b1;
    sb.delete();
    word_bits.delete();
    rem = 0;
    cur_exp = '{IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic lsb_load(input logic [3:0] a, input logic [7:0] b);
    step(1'b1, 1'b0, 4'h0);
    l4_if.ld = 1'b1;
    l4_if.d  = a;
    l8_if.ld = 1'b1;
    l8_if.d  = b;
    for (int i = 0; i < 4; i++) q4.push_back('{a[i], (i == 3)});
    for (int i = 0; i < 8; i++) q8.push_back('{b[i], (i == 7)});
    step(1'b1, 1'b0, 4'h0);
    l4_if.ld = 1'b0;
    l8_if.ld = 1'b0;
    repeat (10) step(1'b1, 1'b0, 4'h0);
  endtask

  // Monitor for the MSB-first DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge c);
      #1;
      if (mon_en) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: DUT cycle with no expected entry");
        end else begin
          e = sb.pop_front();
          check("so_sv_fs_ls_done", 32'({m_if.so, m_if.sv, m_if.fs, m_if.ls, m_if.done}), 32'(e));
        end
      end
    end
  end

  // Monitors for the LSB-first DUTs: one queued bit per valid cycle.
  initial begin
    lbit_t b;
    forever begin
      @(posedge c);
      #1;
      if (l4_if.sv === 1'b1) begin
        if (q4.size() == 0) begin
          n_chk++;
          $display("FAIL lsb4_underflow: unexpected valid bit so=%b", l4_if.so);
        end else begin
          b = q4.pop_front();
          check("lsb4_so_ls", 32'({l4_if.so, l4_if.ls}), 32'(b));
        end
      end
      if (l8_if.sv === 1'b1) begin
        if (q8.size() == 0) begin
          n_chk++;
          $display("FAIL lsb8_underflow: unexpected valid bit so=%b", l8_if.so);
        end else begin
          b = q8.pop_front();
          check("lsb8_so_ls", 32'({l8_if.so, l8_if.ls}), 32'(b));
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    mon_en = 1'b0;
    rem    = 0;
    cur_exp = '{IDLE_LVL, 1'b0, 1'b0, 1'b0, 1'b0};
    m_if.ce = 1'b0;  m_if.ld = 1'b0;  m_if.d = 4'h0;
    l4_if.ce = 1'b1; l4_if.ld = 1'b0; l4_if.d = 4'h0;
    l8_if.ce = 1'b1; l8_if.ld = 1'b0; l8_if.d = 8'h00;

    #1 clr_n = 1'b0;
    #2 check_reset_vals("por");
    @(negedge c);
    @(negedge c);
    #2 clr_n = 1'b1;

    // Basic send
    step(1'b1, 1'b1, 4'b1010);
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // CE gating stretches bit 2
    step(1'b1, 1'b1, 4'b1010);
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'hF);
    repeat (5) step(1'b1, 1'b0, 4'h0);

    // Back-to-back words
    step(1'b1, 1'b1, 4'b1100);
    repeat (3) step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'b0011);
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // Busy load ignored
    step(1'b1, 1'b1, 4'b1001);
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'b0000);
    repeat (5) step(1'b1, 1'b0, 4'h0);

    // Async reset mid-word, then no residue
    step(1'b1, 1'b1, 4'b1010);
    step(1'b1, 1'b0, 4'h0);
    mid_reset();
    repeat (6) step(1'b1, 1'b0, 4'h0);

    // LSB-first variants
    lsb_load(4'b0001, 8'hA5);
    for (int k = 0; k < 4; k++) lsb_load(4'($urandom), 8'($urandom));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 2) == 0), 4'($urandom));
    end
    repeat (8) step(1'b1, 1'b0, 4'h0);

    @(posedge c);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("q4_drain", 32'(q4.size()), 32'd0);
    check("q8_drain", 32'(q8.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_piso_tx.md
Name: v_piso_tx

Overview:
Parallel-in/serial-out transmitter. It is the unload side for the team's CE-gated parallel registers.
- Accepts a WIDTH-bit word through a load/ready handshake.
- Shifts the word out one bit per enabled clock, with valid and framing strobes.
- Downstream serial consumers receive these strobes; upstream logic gets a completion pulse.

Parameters:
WIDTH, 4, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = D[WIDTH-1] is sent first; 0 = D[0] is sent first.
IDLE_LVL, 1, level driven on SO when no bit is valid.

Ports:
C  input  1  clock; all state changes on the rising edge.
CLR_N  input  1  asynchronous, active-low reset.
CE  input  1  clock enable; shifting and loading advance only on edges where CE=1.
LD  input  1  load request; qualified by CE and RDY.
D  input  WIDTH  parallel word; sampled on an accepted load.
RDY  output  1  load can be accepted this cycle.
SO  output  1  serial data bit (registered).
SV  output  1  SO carries a valid bit (registered).
FS  output  1  first bit of a word is on SO (registered).
LS  output  1  last bit of a word is on SO (registered).
DONE  output  1  one-C-cycle pulse: a word has fully left SO.

Behaviour:
- States: IDLE and SHIFT. Internal signals are the shift register SR[WIDTH-1:0] and the bit counter CNT[$clog2(WIDTH)-1:0].
- Reset (CLR_N=0):
  - Takes effect immediately, without waiting for C, including mid-word.
  - The in-flight word is discarded.
  - Resulting values: state=IDLE, SR=all ones, CNT=0, SO=IDLE_LVL, SV=0, FS=0, LS=0, DONE=0.
  - RDY=1 from reset onward.
- RDY is combinational: RDY = (state==IDLE) | LS.
- Accept condition: an accepted load is a rising edge with CE=1, LD=1 and RDY=1.
- On an accepted load:
  - D is captured into SR.
  - SO gets the first bit (MSB or LSB per MSB_FIRST).
  - SV=1, FS=1, CNT=0, state=SHIFT.
  - Latency: the first bit is visible in the cycle after the load edge.
- On each CE=1 edge in SHIFT that is not an accepted load:
  - If CNT<WIDTH-1: SR shifts, SO gets the next bit, CNT+1, FS=0, and LS=1 exactly when the new CNT equals WIDTH-1.
  - If CNT==WIDTH-1 (last bit on SO): state=IDLE, SV=0, SO=IDLE_LVL, LS=0, DONE=1.
- Back-to-back words: an accepted load while LS=1 starts the next word on that same edge.
  - The first bit of the new word follows the last bit with no gap; FS=1 and DONE=1 in the same cycle.
  - SV stays 1 throughout.
- DONE behaviour:
  - DONE is cleared on every C edge on which it is not set, independent of CE.
  - A word therefore produces exactly one DONE cycle.
- CE=0 edges: SR, CNT, state, SO, SV, FS and LS hold; a bit is stretched over the gated cycles. LD is ignored.
- LD with RDY=0 is ignored: SR and the word in flight are unaffected, with no error indication.
- Word period without back-to-back loading: WIDTH CE-cycles of valid bits, then at least one IDLE cycle before the next load edge.

Test Plan:
1. Async reset: assert CLR_N=0 between clock edges while the 2nd bit of 4'b1010 is on SO -> immediately SO=1, SV=0, FS=0, LS=0, RDY=1. After release, no residual bits appear.
2. Basic send: MSB_FIRST=1, CE=1, load D=4'b1010 -> in cycles 1..4 SO=1,0,1,0 with SV=1; FS in cycle 1 only; LS in cycle 4 only; cycle 5 SV=0, SO=1, DONE=1, RDY=1.
3. CE gating: same word, CE=0 for 2 edges after bit 2 appears -> SO holds 0 for 3 cycles. The sequence then resumes 1,0; a single DONE follows bit 4.
4. Back-to-back: load 4'b1100, then 4'b0011 with LD=1 while LS=1 -> SV=1 for 8 consecutive cycles with SO=1,1,0,0,0,0,1,1. FS in cycles 1 and 5; DONE in cycles 5 and 9.
5. Busy load ignored: during bit 2 of 4'b1001, assert LD with D=4'b0000 -> the output remains 1,0,0,1, with no extra FS.
6. LSB-first: MSB_FIRST=0, WIDTH=4, load 4'b0001 -> SO=1,0,0,0. With WIDTH=8 and 8'hA5 the sequence is 1,0,1,0,0,1,0,1, with LS on bit 8.
